spi_reg_slave: RTL

- Synthesizable SPI slave (responder) that terminates the 16-bit frames issued by the apb_to_spi master.
- Frame format: an 8-bit command byte, then an 8-bit data byte, MSB first.
  - Command bit7: R/W, where 1 = read.
  - Command bits 6:0: register address.
- Owns a small 8-bit register file, exposed in parallel to local logic.
- All SPI pins are oversampled in the PCLK domain; there are no SCLK-clocked flops.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_reg_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI register slave.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } spi_state_e;

   localparam int FRAME_BITS = 16;
   localparam int CMD_BITS   = 8;
   localparam int CMD_RW_BIT = 7;
   localparam int ADDR_W     = 7;
   localparam int CNT_W      = 5;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulse outputs.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_lvl;

   assign w_lvl = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_lvl;
         o_rise <= w_lvl & ~r_prev;
         o_fall <= ~w_lvl & r_prev;
      end
   end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave terminating 16-bit cmd/data frames into an 8-bit register file.
// Optional SPI_REG_SLAVE_ERR_EN adds abort flag and saturating abort counter.
//
// state   | meaning
// IDLE    | SS_n high or waiting for a fresh SS_n falling edge
// CMD     | shifting in the command byte
// DATA    | shifting write data in, or read shadow out on MISO
// DONE    | frame complete, SCLK ignored until SS_n rises
module spi_reg_slave
   import spi_pkg::*;
#(
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int NREGS       = 8,
   parameter int SYNC_STAGES = 2
)(
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic               SCLK,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic               MISO_OE,
   output logic [NREGS*8-1:0] regs_o,
   output logic               wr_strobe,
   output logic [6:0]         wr_addr,
   output logic [7:0]         wr_data
`ifdef SPI_REG_SLAVE_ERR_EN
   ,
   output logic               err_o,
   output logic [7:0]         err_cnt_o
`endif
);

   logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
   logic w_lead, w_trail, w_sample, w_shift, w_mosi;
   logic [SYNC_STAGES-1:0] r_mosi_sync;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_async (SCLK),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   // SS_n resets low so a select already held after reset never looks like a fresh fall.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_async (SS_n),
      .o_rise  (w_ss_rise),
      .o_fall  (w_ss_fall)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_mosi_sync <= '0;
      else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
   end

   assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
   assign w_lead   = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
   assign w_trail  = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
   assign w_sample = (CPHA != 0) ? w_trail : w_lead;
   assign w_shift  = (CPHA != 0) ? w_lead  : w_trail;

   spi_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [7:0]        r_sr, w_sr_nxt;
   logic [7:0]        r_shadow, w_shadow_nxt;
   logic              r_rd, w_rd_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic              r_miso, w_miso_nxt;
   logic              r_oe, w_oe_nxt;
   logic              r_wr_strobe, w_wr_strobe_nxt;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]        r_wr_data, w_wr_data_nxt;
   logic              w_commit;
   logic [7:0]        w_rd_val;
   logic              w_addr_hit;
   logic [7:0]        r_regs [NREGS];

   // Out-of-range addresses simply find no match: reads return 0, writes miss.
   always_comb begin
      w_rd_val = '0;
      for (int k = 0; k < NREGS; k++)
         if (r_sr[ADDR_W-1:0] == ADDR_W'(k)) w_rd_val = r_regs[k];
   end

   always_comb begin
      w_addr_hit = 1'b0;
      for (int k = 0; k < NREGS; k++)
         if (r_addr == ADDR_W'(k)) w_addr_hit = 1'b1;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_sr_nxt        = r_sr;
      w_shadow_nxt    = r_shadow;
      w_rd_nxt        = r_rd;
      w_addr_nxt      = r_addr;
      w_miso_nxt      = r_miso;
      w_oe_nxt        = r_oe;
      w_wr_strobe_nxt = 1'b0;
      w_wr_addr_nxt   = r_wr_addr;
      w_wr_data_nxt   = r_wr_data;
      w_commit        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = ST_CMD;
               w_cnt_nxt   = '0;
               w_sr_nxt    = '0;
               w_oe_nxt    = 1'b1;
               w_miso_nxt  = 1'b0;
            end
         end
         ST_CMD: begin
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_oe_nxt    = 1'b0;
               w_miso_nxt  = 1'b0;
            end else if (r_cnt == CNT_W'(CMD_BITS)) begin
               w_state_nxt  = ST_DATA;
               w_rd_nxt     = r_sr[CMD_RW_BIT];
               w_addr_nxt   = r_sr[ADDR_W-1:0];
               w_shadow_nxt = r_sr[CMD_RW_BIT] ? w_rd_val : 8'h00;
               w_sr_nxt     = '0;
            end else if (w_sample) begin
               w_sr_nxt  = {r_sr[6:0], w_mosi};
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            // SS_n rise is checked first so a simultaneous 16th sample never commits.
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_oe_nxt    = 1'b0;
               w_miso_nxt  = 1'b0;
            end else if (r_cnt == CNT_W'(FRAME_BITS)) begin
               w_state_nxt = ST_DONE;
               w_miso_nxt  = 1'b0;
               if (!r_rd && w_addr_hit) begin
                  w_commit        = 1'b1;
                  w_wr_strobe_nxt = 1'b1;
                  w_wr_addr_nxt   = r_addr;
                  w_wr_data_nxt   = r_sr;
               end
            end else begin
               if (w_sample) begin
                  w_sr_nxt  = {r_sr[6:0], w_mosi};
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
               if (w_shift && r_rd) begin
                  w_miso_nxt   = r_shadow[7];
                  w_shadow_nxt = {r_shadow[6:0], 1'b0};
               end
            end
         end
         ST_DONE: begin
            w_miso_nxt = 1'b0;
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_oe_nxt    = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_sr        <= '0;
         r_shadow    <= '0;
         r_rd        <= 1'b0;
         r_addr      <= '0;
         r_miso      <= 1'b0;
         r_oe        <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sr        <= w_sr_nxt;
         r_shadow    <= w_shadow_nxt;
         r_rd        <= w_rd_nxt;
         r_addr      <= w_addr_nxt;
         r_miso      <= w_miso_nxt;
         r_oe        <= w_oe_nxt;
         r_wr_strobe <= w_wr_strobe_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
      end else if (w_commit) begin
         for (int k = 0; k < NREGS; k++)
            if (r_addr == ADDR_W'(k)) r_regs[k] <= r_sr;
      end
   end

   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NREGS; k++) regs_o[8*k +: 8] = r_regs[k];
   end

   assign MISO      = r_miso;
   assign MISO_OE   = r_oe;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

`ifdef SPI_REG_SLAVE_ERR_EN
   logic       w_abort, w_complete, r_err;
   logic [7:0] r_err_cnt;

   assign w_abort    = w_ss_rise && (r_state == ST_CMD || r_state == ST_DATA);
   assign w_complete = !w_ss_rise && r_state == ST_DATA && r_cnt == CNT_W'(FRAME_BITS);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_abort) begin
         r_err <= 1'b1;
         if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (w_complete) begin
         r_err <= 1'b0;
      end
   end

   assign err_o     = r_err;
   assign err_cnt_o = r_err_cnt;
`endif

endmodule
